// File: rtl/alu_pipe.sv
// Pipelined CGRA ALU function cell with an elastic valid/ready handshake,
// a configurable number of delay stages and an optional MAC accumulator.
module alu_pipe #(
  parameter int size        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int ACC_EN      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      config_sig,
  input  logic [size-1:0] in0,
  input  logic [size-1:0] in1,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [size-1:0] out0,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int SH_W = $clog2(size);

  // Handshake: a beat is taken when in_valid && in_ready, a result leaves when
  // out_valid && out_ready. in_ready drops only while the last stage holds an
  // unconsumed result, and then the whole pipe freezes (no bubble collapsing).
  logic stall;
  logic accept;

  logic [PIPE_STAGES-1:0] vld;
  logic [size-1:0]        dat [PIPE_STAGES];

  logic [size-1:0] acc_q;
  logic [size-1:0] acc_next;
  logic            acc_we;
  logic [size-1:0] result;
  logic [size-1:0] prod;
  logic [size-1:0] mac_sum;
  logic [SH_W-1:0] sh;
  logic            lt_s;

  assign out_valid = vld[PIPE_STAGES-1];
  assign out0      = dat[PIPE_STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;

  assign sh      = in1[SH_W-1:0];
  assign prod    = in0 * in1;
  assign mac_sum = acc_q + prod;
  assign lt_s    = $signed(in0) < $signed(in1);

  always_comb begin
    result   = '0;
    acc_next = acc_q;
    acc_we   = 1'b0;
    case (config_sig)
      5'd0:  result = in0 + in1;
      5'd1:  result = in0 - in1;
      5'd2:  result = prod;
      5'd3:  result = in0 & in1;
      5'd4:  result = in0 | in1;
      5'd5:  result = in0 ^ in1;
      5'd6:  result = in0 << sh;
      5'd7:  result = in0 >> sh;
      5'd8:  result = in0;
      5'd9:  result = in1;
      5'd10: result = {{(size-1){1'b0}}, lt_s};
      5'd11: result = $signed(in0) >>> sh;
      5'd12: begin
        // The accumulator lives in stage 1, so the next beat already sees it.
        if (ACC_EN != 0) begin
          result   = mac_sum;
          acc_next = mac_sum;
          acc_we   = 1'b1;
        end
      end
      5'd13: begin
        if (ACC_EN != 0) begin
          result   = in0;
          acc_next = in0;
          acc_we   = 1'b1;
        end
      end
      5'd14: result = lt_s ? in0 : in1;
      5'd15: result = lt_s ? in1 : in0;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) dat[i] <= '0;
    end else if (!stall) begin
      vld[0] <= accept;
      if (accept) dat[0] <= result;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  generate
    if (ACC_EN != 0) begin : g_acc
      always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else if (accept && acc_we) acc_q <= acc_next;
      end
    end else begin : g_no_acc
      assign acc_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed beats feed a scoreboard queue, a negedge
// monitor pops and compares every consumed result (with and without MAC).
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   config_sig;
  logic [W-1:0] in0, in1;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] out0;
  logic         in_ready_na, out_valid_na;
  logic [W-1:0] out0_na;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_na_q[$];
  int n_vec = 0;
  int n_mis = 0;

  alu_pipe #(.size(W), .PIPE_STAGES(2), .ACC_EN(1)) u_dut (
    .clk(clk), .reset(reset), .config_sig(config_sig), .in0(in0), .in1(in1),
    .in_valid(in_valid), .in_ready(in_ready), .out0(out0),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  alu_pipe #(.size(W), .PIPE_STAGES(2), .ACC_EN(0)) u_noacc (
    .clk(clk), .reset(reset), .config_sig(config_sig), .in0(in0), .in1(in1),
    .in_valid(in_valid), .in_ready(in_ready_na), .out0(out0_na),
    .out_valid(out_valid_na), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every consumed result is compared against the head of its queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL out0_unexpected got=%h exp=none", out0);
      end else check("out0", out0, exp_q.pop_front());
    end
    if (!reset && out_valid_na && out_ready) begin
      if (exp_na_q.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL out0_na_unexpected got=%h exp=none", out0_na);
      end else check("out0_na", out0_na, exp_na_q.pop_front());
    end
  end

  // Tasks start and end 1ns after a rising edge.
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp);
    bit ok = 0;
    config_sig = op; in0 = a; in1 = b; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_mis++;
      $display("FAIL send_timeout got=in_ready_low exp=accept op=%0d", op);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(exp);
      exp_na_q.push_back((op == 5'd12 || op == 5'd13) ? '0 : exp);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] vs [5];

  initial begin
    reset = 1'b1; in_valid = 1'b0; config_sig = '0; in0 = '0; in1 = '0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out0", out0, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency: accepted at the edge send returns from, valid two edges later.
    send(5'd0, 32'd5, 32'd7, 32'd12);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    idle(3);

    // Reset one cycle after acceptance discards the in-flight beat.
    send(5'd0, 32'd5, 32'd7, 32'd12);
    in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete(); exp_na_q.delete();
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_out_valid", {31'd0, out_valid | out_valid_na}, 32'd0);
      check("postrst_out0", out0, 32'd0);
      check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;

    // Accumulator starts at zero after reset, then back-to-back MACs.
    send(5'd12, 32'd3, 32'd4, 32'd12);
    send(5'd13, 32'd10, 32'd0, 32'd10);
    send(5'd12, 32'd3, 32'd4, 32'd22);
    send(5'd12, 32'd2, 32'hFFFF_FFFF, 32'd20);
    idle(4);

    // Backpressure: out_ready low from the first out_valid for three cycles.
    out_ready = 1'b0;
    fork
      begin
        send(5'd1, 32'd9, 32'd4, 32'd5);
        send(5'd1, 32'd8, 32'd1, 32'd7);
        send(5'd1, 32'd7, 32'd7, 32'd0);
        in_valid = 1'b0;
      end
      begin
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) begin seen = 1; break; end
        end
        if (!seen) begin
          n_vec++; n_mis++;
          $display("FAIL bp_wait got=no_out_valid exp=out_valid");
        end
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_out_valid", {31'd0, out_valid}, 32'd1);
          check("bp_out0_hold", out0, 32'd5);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle(4);

    // Signed ops, wrap-around and shift-amount masking, misc logic ops.
    send(5'd10, 32'hFFFF_FFFF, 32'd1, 32'd1);
    send(5'd10, 32'd1, 32'hFFFF_FFFF, 32'd0);
    send(5'd11, 32'h8000_0000, 32'd4, 32'hF800_0000);
    send(5'd7,  32'h8000_0000, 32'd4, 32'h0800_0000);
    send(5'd14, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFD);
    send(5'd15, 32'hFFFF_FFFD, 32'd2, 32'd2);
    send(5'd0,  32'hFFFF_FFFF, 32'd1, 32'd0);
    send(5'd6,  32'd1, 32'd33, 32'd2);
    send(5'd2,  32'h0001_0000, 32'h0001_0000, 32'd0);
    send(5'd2,  32'd7, 32'd6, 32'd42);
    send(5'd20, 32'd5, 32'd6, 32'd0);
    send(5'd1,  32'd3, 32'd5, 32'hFFFF_FFFE);
    send(5'd3,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    send(5'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    send(5'd5,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    send(5'd8,  32'hAA, 32'hBB, 32'hAA);
    send(5'd9,  32'hAA, 32'hBB, 32'hBB);
    // None of the above touched the accumulator, still 20.
    send(5'd12, 32'd1, 32'd1, 32'd21);
    idle(4);

    // Bubbles: in_valid 1,0,1 appears as out_valid 1,0,1 two cycles later.
    send(5'd0, 32'd1, 32'd1, 32'd2);
    fork
      begin
        idle(1);
        send(5'd0, 32'd2, 32'd2, 32'd4);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          vs[i] = {30'd0, out_valid_na, out_valid};
        end
      end
    join
    check("bub_0", vs[0], 32'd0);
    check("bub_1", vs[1], 32'd3);
    check("bub_2", vs[2], 32'd0);
    check("bub_3", vs[3], 32'd3);
    check("bub_4", vs[4], 32'd0);
    @(posedge clk); #1;

    idle(6);
    check("drain_q", exp_q.size(), 32'd0);
    check("drain_na_q", exp_na_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-register CGRA ALU function cell.
- Adds an elastic valid/ready handshake and a configurable pipeline depth.
- Adds signed compare, arithmetic-shift and min/max opcodes.
- Adds an internal accumulator for multiply-accumulate.
- Sits in a PE as a FUNC_CELL between the input muxes and the output router; config_sig is supplied per beat.

Parameters:
- size, 32: datapath width in bits (>= 8).
- PIPE_STAGES, 2: cycles from input acceptance to out_valid (1..4).
- ACC_EN, 1: 1 instantiates the accumulator; 0 removes it, and opcodes 12/13 then produce 0.

Ports:
- clk: input, 1, rising-edge clock.
- reset: input, 1, asynchronous, active-high; clears all state.
- config_sig: input, 5, opcode, sampled with each accepted input beat.
- in0: input, size, operand A.
- in1: input, size, operand B.
- in_valid: input, 1, operand beat present.
- in_ready: output, 1, block can accept a beat this cycle.
- out0: output, size, result.
- out_valid: output, 1, out0 holds a valid result.
- out_ready: input, 1, downstream accepts out0 this cycle.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits = 0; out_valid = 0.
  - out0 = 0 and acc = 0.
  - in_ready = 1 once reset deasserts.
  - Reset mid-operation discards all in-flight beats; no partial result ever appears.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational; there is no bubble-collapsing.
  - While stalled, every stage register holds: out0 and out_valid stay stable, and the accumulator does not update.
- Pipeline:
  - Stage 1 computes the result from in0, in1 and config_sig at acceptance.
  - Stages 2..PIPE_STAGES are pure delay registers with valid bits.
  - Latency is exactly PIPE_STAGES cycles with no stall; throughput is 1 beat/cycle when out_ready = 1.
  - Cycles with no accepted beat propagate valid = 0 bubbles.
- Opcodes (size-bit wrap-around arithmetic; sh = in1[clog2(size)-1:0]):
  - 0: add.
  - 1: sub (in0 - in1).
  - 2: mul (low size bits).
  - 3: and.
  - 4: or.
  - 5: xor.
  - 6: shl by sh.
  - 7: logical shr by sh.
  - 8: pass in0.
  - 9: pass in1.
  - 10: signed in0 < in1 ? 1 : 0.
  - 11: arithmetic shr by sh.
  - 12: MAC, acc <= acc + in0*in1 (low size bits); result = new acc.
  - 13: acc <= in0; result = in0.
  - 14: signed min.
  - 15: signed max.
  - 16..31: result 0.
- Accumulator:
  - Updates only on an accepted beat with opcode 12 or 13.
  - Back-to-back MACs must see the previous beat's update; the forwarding is internal, and a correct running sum is required with no stall bubbles.
  - Any other opcode leaves acc unchanged.
- Simultaneous events:
  - A downstream consume and a new accept in the same cycle are both legal; the pipeline advances.
  - Reset overrides all other events.

Test Plan:
- Latency and reset (size=32, PIPE_STAGES=2): accept add in0=5, in1=7 at cycle 0 with out_ready=1 → out_valid=1 and out0=12 at cycle 2; assert reset at cycle 1 instead → out_valid never rises and out0=0.
- Back-to-back MAC: op13 in0=10, then op12 (3,4), then op12 (2,-1) on consecutive cycles → outputs 10, 22, 20 in order on consecutive cycles.
- Backpressure: stream sub beats (9,4), (8,1), (7,7) while holding out_ready=0 from the first out_valid for 3 cycles → in_ready=0 during the stall, out0=5 held stable, then 5, 7, 0 delivered with no loss or duplication.
- Signed ops:
  - op10 (0xFFFFFFFF, 1) → 1.
  - op11 (0x80000000, 4) → 0xF8000000.
  - op7 (0x80000000, 4) → 0x08000000.
  - op14 (-3, 2) → 0xFFFFFFFD.
  - op15 (-3, 2) → 2.
- Wrap and masking:
  - op0 (0xFFFFFFFF, 1) → 0.
  - op6 (1, 33) → 2, since sh = 1.
  - op2 (0x10000, 0x10000) → 0.
  - op20 (any operands) → 0.
- ACC_EN=0 and bubbles: op12 (3,4) → 0; in_valid toggling 1,0,1 → out_valid pattern 1,0,1 delayed by PIPE_STAGES.
